// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter for the register file's single write port, with hazard query.
module regfile_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int CNT_W = 16
) (
  input  logic               elk,
  input  logic               nrst,
  input  logic               hold,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [5*N_REQ-1:0] req_addr,
  input  logic [32*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               wr_en,
  output logic [4:0]         wr_addr,
  output logic [31:0]        wr_data,
  input  logic [4:0]         qry_addrA,
  input  logic [4:0]         qry_addrB,
  output logic               qry_pendA,
  output logic               qry_pendB,
  output logic [CNT_W-1:0]   wr_count
);
  localparam int PW = $clog2(N_REQ);
  localparam logic [PW:0] NQ = (PW+1)'(N_REQ);
  logic [PW-1:0] ptr, off, idx;
  logic [PW:0] sum;
  logic [2*N_REQ-1:0] dbl;
  logic found, xfer, hit_a, hit_b;
  logic [4:0] sel_addr;
  logic [31:0] sel_data;
  // rotate requests so bit 0 is the current priority holder, then take the lowest set bit
  always_comb begin
    dbl = {req_valid, req_valid} >> ptr;
    found = 1'b0;
    off = '0;
    for (int k = N_REQ-1; k >= 0; k--)
      if (dbl[k]) begin
        found = 1'b1;
        off = PW'(k);
      end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= NQ) ? PW'(sum - NQ) : PW'(sum);
    sel_addr = '0;
    sel_data = '0;
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (idx == PW'(k)) begin
        sel_addr = req_addr[5*k +: 5];
        sel_data = req_data[32*k +: 32];
      end
      if (req_valid[k] && req_addr[5*k +: 5] == qry_addrA) hit_a = 1'b1;
      if (req_valid[k] && req_addr[5*k +: 5] == qry_addrB) hit_b = 1'b1;
    end
    xfer = found & ~hold & ~nrst;
    req_ready = xfer ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx) : '0;
    qry_pendA = (qry_addrA != 5'd0) && (hit_a || (wr_en && wr_addr == qry_addrA));
    qry_pendB = (qry_addrB != 5'd0) && (hit_b || (wr_en && wr_addr == qry_addrB));
  end
  always_ff @(posedge elk) begin
    if (nrst) begin
      ptr <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_count <= '0;
    end else begin
      wr_en <= xfer && sel_addr != 5'd0;
      if (xfer) begin
        ptr <= (idx == PW'(N_REQ-1)) ? '0 : idx + 1'b1;
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
      if (xfer && sel_addr != 5'd0) wr_count <= wr_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of arbitration, r0 discard, hold, hazards and reset.
module tb_regfile_wb_arbiter;
  logic elk = 1'b0;
  logic nrst, hold;
  logic [2:0] req_valid, req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic wr_en, qry_pendA, qry_pendB;
  logic [4:0] wr_addr, qry_addrA, qry_addrB;
  logic [31:0] wr_data;
  logic [15:0] wr_count;
  int tests = 0;
  int fails = 0;
  regfile_wb_arbiter #(.N_REQ(3), .CNT_W(16)) dut (
    .elk(elk), .nrst(nrst), .hold(hold), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .qry_addrA(qry_addrA), .qry_addrB(qry_addrB),
    .qry_pendA(qry_pendA), .qry_pendB(qry_pendB), .wr_count(wr_count)
  );
  always #5 elk = ~elk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge elk);
    #1;
  endtask
  initial begin
    nrst = 1'b1;
    hold = 1'b0;
    req_valid = 3'b111;
    req_addr = {5'd7, 5'd6, 5'd5};
    req_data = {32'hC, 32'hB, 32'hA};
    qry_addrA = 5'd0;
    qry_addrB = 5'd0;
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_count", 32'(wr_count), 32'h0);
    nrst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    for (int c = 0; c < 6; c++) begin
      chk("rr_ready", 32'(req_ready), 32'(1 << (c % 3)));
      step();
      chk("rr_wr_en", 32'(wr_en), 32'h1);
      chk("rr_wr_addr", 32'(wr_addr), 32'(5 + c % 3));
      chk("rr_wr_data", wr_data, 32'(10 + c % 3));
    end
    req_valid = 3'b000;
    chk("rr_count", 32'(wr_count), 32'd6);
    req_valid = 3'b010;
    req_addr[5 +: 5] = 5'd0;
    req_data[32 +: 32] = 32'hDEADBEEF;
    #1;
    chk("r0_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 3'b000;
    chk("r0_wr_en", 32'(wr_en), 32'h0);
    chk("r0_wr_addr", 32'(wr_addr), 32'h0);
    chk("r0_wr_data", wr_data, 32'hDEADBEEF);
    chk("r0_count", 32'(wr_count), 32'd6);
    req_addr[5 +: 5] = 5'd6;
    req_data[32 +: 32] = 32'hB;
    req_valid = 3'b111;
    #1;
    chk("r0_ptr2", 32'(req_ready), 32'h4);
    req_valid = 3'b010;
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_ready", 32'(req_ready), 32'h0);
      step();
      chk("hold_wr_en", 32'(wr_en), 32'h0);
    end
    hold = 1'b0;
    #1;
    chk("unhold_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 3'b000;
    chk("unhold_wr_en", 32'(wr_en), 32'h1);
    chk("unhold_wr_addr", 32'(wr_addr), 32'd6);
    chk("unhold_count", 32'(wr_count), 32'd7);
    step();
    chk("unhold_once", 32'(wr_en), 32'h0);
    req_addr[0 +: 5] = 5'd0;
    req_addr[10 +: 5] = 5'd9;
    req_data[64 +: 32] = 32'h99;
    req_valid = 3'b101;
    qry_addrA = 5'd9;
    qry_addrB = 5'd0;
    #1;
    chk("haz_ready", 32'(req_ready), 32'h4);
    chk("haz_pendA_req", 32'(qry_pendA), 32'h1);
    chk("haz_pendB_r0", 32'(qry_pendB), 32'h0);
    step();
    req_valid = 3'b001;
    #1;
    chk("haz_wr_addr", 32'(wr_addr), 32'd9);
    chk("haz_pendA_out", 32'(qry_pendA), 32'h1);
    chk("haz_pendB_r0b", 32'(qry_pendB), 32'h0);
    chk("haz_ready0", 32'(req_ready), 32'h1);
    step();
    req_valid = 3'b000;
    #1;
    chk("haz_pendA_clr", 32'(qry_pendA), 32'h0);
    chk("haz_r0_wr_en", 32'(wr_en), 32'h0);
    chk("haz_count", 32'(wr_count), 32'd8);
    req_valid = 3'b010;
    #1;
    chk("mid_ready", 32'(req_ready), 32'h2);
    nrst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    step();
    chk("mid_wr_en", 32'(wr_en), 32'h0);
    chk("mid_count", 32'(wr_count), 32'h0);
    chk("mid_wr_addr", 32'(wr_addr), 32'h0);
    nrst = 1'b0;
    req_valid = 3'b111;
    #1;
    chk("mid_ptr0", 32'(req_ready), 32'h1);
    req_valid = 3'b010;
    #1;
    chk("mid_regrant", 32'(req_ready), 32'h2);
    step();
    req_valid = 3'b000;
    chk("mid_wr_en2", 32'(wr_en), 32'h1);
    chk("mid_wr_addr2", 32'(wr_addr), 32'd6);
    chk("mid_count2", 32'(wr_count), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the register file's single write port between `N_REQ` writeback requesters: ALU result, load return, multiply/divide unit.
- Grants one requester per cycle using round-robin priority, then registers the granted write onto `wr_en`/`wr_addr`/`wr_data`.
- Reports pending-write hazards for two read addresses, so decode can stall.
- Discards all writes to register 0.

## Interface
Parameters:
- `N_REQ`, default 3: number of writeback requesters (2..8).
- `CNT_W`, default 16: width of the issued-write counter.

Ports:
- `elk`  in  1: clock, rising-edge.
- `nrst`  in  1: reset, synchronous, active-high.
- `hold`  in  1: when 1, no grants are issued (used while the register file is being cleared).
- `req_valid`  in  `N_REQ`: per-requester write request.
- `req_addr`  in  `5*N_REQ`: destination register; requester i uses bits [5i+4:5i].
- `req_data`  in  `32*N_REQ`: write data; requester i uses bits [32i+31:32i].
- `req_ready`  out  `N_REQ`: grant, one-hot or zero, combinational.
- `wr_en`  out  1: register-file write enable, registered.
- `wr_addr`  out  5: register-file write address, registered.
- `wr_data`  out  32: register-file write data, registered.
- `qry_addrA`, `qry_addrB`  in  5: read addresses to check.
- `qry_pendA`, `qry_pendB`  out  1: a write to that address is still outstanding, combinational.
- `wr_count`  out  `CNT_W`: number of register-file writes issued, wrapping.

## Operation
- **Handshake.** Requester i transfers on a cycle where `req_valid[i]` and `req_ready[i]` are both 1.
  - The requester must hold `req_addr`/`req_data` stable while `req_valid` is 1 and it has no grant.
  - `req_valid` must not drop before the grant.
- **Arbitration.**
  - Priority pointer `ptr` ranges 0..`N_REQ`-1.
  - The granted requester is the first i with `req_valid[i]=1`, scanning `ptr`, `ptr`+1, … modulo `N_REQ`.
  - After a grant to i, `ptr` becomes (i+1) mod `N_REQ`.
  - With no grant, `ptr` is unchanged.
- **Grant suppression.** `req_ready` is all-zero whenever `hold`=1 or `nrst`=1.
- **Output stage.** On the cycle after a transfer from requester i:
  - `wr_addr` = `req_addr[i]`, `wr_data` = `req_data[i]`.
  - `wr_en` = 1 only if `req_addr[i]` ≠ 0.
  - A transfer to address 0 completes normally: the requester sees its grant, but `wr_en` stays 0 and `wr_count` does not increment.
- **Idle output.** On a cycle with no transfer:
  - `wr_en` = 0.
  - `wr_addr`/`wr_data` hold their previous values.
- **Counter.** `wr_count` increments by 1 in the same cycle `wr_en` is registered to 1. It wraps from all-ones to 0.
- **Same-address conflict.** When two requesters target the same address, they are granted in round-robin order, and the later grant's data is what remains in the register file. Upstream ensures program order when that matters.
- **Hazard query.** `qry_pendX` = 1 iff `qry_addrX` ≠ 0 and either:
  - some requester has `req_valid`=1 with matching `req_addr` (granted this cycle or not), or
  - the output stage currently has `wr_en`=1 with a matching `wr_addr`.

## Timing
- **Latency.** Handshake at edge k → `wr_en` high during cycle k+1 → register file written at edge k+2.
- **Throughput.** One write per cycle; with all requesters continuously valid, each is granted once every `N_REQ` cycles.
- **Reset (`nrst`=1 at an edge):**
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_count`=0, `ptr`=0.
  - A transfer that coincides with reset is dropped, because `req_ready` is forced to 0.
- **Hold.**
  - Asserting `hold` blocks new grants from that cycle on.
  - A write already registered in the output stage still issues on the next cycle.
  - Deasserting `hold` resumes arbitration from the unchanged `ptr`.
- **Hazard latency.** `qry_pendX` is valid in the same cycle as `qry_addrX` (combinational, no registers).

## Test plan
- **Reset.** Assert `nrst` for 2 cycles with `req_valid`=111 → `req_ready`=000, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_count`=0. First cycle after release → `req_ready`=001.
- **Round-robin.** Hold `req_valid`=111 with addresses 5, 6, 7 and data 0xA, 0xB, 0xC for 6 cycles → grants 0,1,2,0,1,2; `wr_addr` sequence 5,6,7,5,6,7, each one cycle after its grant; `wr_count`=6.
- **r0 discard.** Requester 1 writes address 0 with data 0xDEADBEEF → `req_ready[1]` pulses once, `wr_en` stays 0, `wr_count` unchanged, `ptr`=2.
- **Hold.** With `req_valid`=010, assert `hold` for 3 cycles → no grant during hold. Release → grant to requester 1 in the first cycle. `wr_en` is high exactly once.
- **Hazard.**
  - Requester 2 valid to address 9, `qry_addrA`=9 → `qry_pendA`=1 until the cycle after its `wr_en` pulse, then 0.
  - `qry_addrB`=0 with a pending write to 0 → `qry_pendB`=0.
- **Reset mid-stream.** Assert `nrst` on the cycle of a grant to requester 1 → that write never appears on `wr_en`, `ptr`=0 afterwards, and requester 1 is regranted after reset releases.
